// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a framed byte stream
// (16-bit word count, little-endian words, XOR checksum) and holds the
// processor in reset until a load has completed with a good checksum.
module imem_loader #(
    parameter int NUM_INST   = 128,
    parameter int REG_WIDTH  = 32,
    parameter int ADDR_WIDTH = $clog2(NUM_INST)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [REG_WIDTH-1:0]  imem_wdata,
    output logic                  cpu_rstn,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state_q;
    logic [1:0]            byte_cnt_q;
    logic [15:0]           len_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            csum_q;
    logic [23:0]           asm_q;      // low three bytes of the word being built
    logic                  imem_we_q;
    logic [ADDR_WIDTH-1:0] imem_waddr_q;
    logic [REG_WIDTH-1:0]  imem_wdata_q;
    logic                  cpu_rstn_q;
    logic                  done_q;
    logic                  error_q;

    logic                  accept;
    logic [15:0]           len_d;
    logic                  last_word;

    // The loader can take bytes only while a frame is in progress
    always_comb begin
        byte_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
        busy       = byte_ready;
        accept     = byte_valid && byte_ready;
        len_d      = {byte_data, len_q[7:0]};
        last_word  = (16'(addr_q) + 16'd1) == len_q;
    end

    assign imem_we    = imem_we_q;
    assign imem_waddr = imem_waddr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_rstn   = cpu_rstn_q;
    assign done       = done_q;
    assign error      = error_q;

    // Frame parser FSM with registered memory-write and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= 2'd0;
            len_q        <= 16'd0;
            addr_q       <= '0;
            csum_q       <= 8'd0;
            asm_q        <= 24'd0;
            imem_we_q    <= 1'b0;
            imem_waddr_q <= '0;
            imem_wdata_q <= '0;
            cpu_rstn_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (state_q == S_IDLE) begin
                        cpu_rstn_q <= 1'b0;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                    end
                    if (start) begin
                        state_q    <= S_LEN;
                        byte_cnt_q <= 2'd0;
                        len_q      <= 16'd0;
                        addr_q     <= '0;
                        csum_q     <= 8'd0;
                        cpu_rstn_q <= 1'b0;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        csum_q <= csum_q ^ byte_data;
                        if (byte_cnt_q == 2'd0) begin
                            len_q[7:0] <= byte_data;
                            byte_cnt_q <= 2'd1;
                        end else begin
                            len_q      <= len_d;
                            byte_cnt_q <= 2'd0;
                            // oversize frames stop here so the address can never overrun
                            if (len_d > 16'(NUM_INST)) begin
                                state_q <= S_ERROR;
                                error_q <= 1'b1;
                            end else if (len_d == 16'd0) begin
                                state_q <= S_CSUM;
                            end else begin
                                state_q <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        csum_q     <= csum_q ^ byte_data;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0: asm_q[7:0]   <= byte_data;
                            2'd1: asm_q[15:8]  <= byte_data;
                            2'd2: asm_q[23:16] <= byte_data;
                            default: begin
                                imem_we_q    <= 1'b1;
                                imem_waddr_q <= addr_q;
                                imem_wdata_q <= {byte_data, asm_q};
                                addr_q       <= addr_q + 1'b1;
                                if (last_word) state_q <= S_CSUM;
                            end
                        endcase
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        if (byte_data == csum_q) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            cpu_rstn_q <= 1'b1;
                        end else begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
